// File: rtl/btb_update_ctrl_pkg.sv
// Shared types and constants for the BTB update controller and its queue.
package btb_update_ctrl_pkg;

  localparam int ADDR_W    = 32;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Circular update queue holding {pc, target} pairs; head is read combinationally.
module btb_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (PTR_W+1)'(DEPTH));
  assign empty     = (count_r == (PTR_W+1)'(0));
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_r + (PTR_W+1)'(do_push_s) - (PTR_W+1)'(do_pop_s);
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (do_push_s && !clear) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Buffers taken branch resolutions into BTB writes and sequences a full-BTB
// valid-bit sweep on flush.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              res_valid,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic [ADDR_W-1:0] res_target,
  input  logic              res_taken,
  output logic              res_ready,
  input  logic              flush_req,
  output logic              btb_update_en,
  output logic [ADDR_W-1:0] btb_pc,
  output logic [ADDR_W-1:0] btb_target,
  output logic              btb_taken,
  output logic              btb_clear_en,
  output logic [IDX_W-1:0]  btb_clear_idx,
  output logic              busy,
  output logic              flush_done
);

  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  state_t                state_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  clear_s;
  logic [2*ADDR_W-1:0]   head_s;

  btb_upd_fifo #(
    .DEPTH (DEPTH),
    .W     (2*ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear_s),
    .push      (push_s),
    .push_data ({res_pc, res_target}),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Handshake and queue control; flush wins over both accept and pop.
  always_comb begin
    res_ready = 1'b0;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    clear_s   = 1'b0;
    if (state_r == ST_IDLE) begin
      res_ready = !full_s && !flush_req;
      clear_s   = flush_req;
      pop_s     = !empty_s && !flush_req;
      push_s    = res_valid && res_ready && res_taken;
    end else begin
      res_ready = 1'b0;
    end
  end

  // Controller FSM; the clear index register doubles as the sweep counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      btb_update_en <= 1'b0;
      btb_pc        <= {ADDR_W{1'b0}};
      btb_target    <= {ADDR_W{1'b0}};
      btb_taken     <= 1'b0;
      btb_clear_en  <= 1'b0;
      btb_clear_idx <= {IDX_W{1'b0}};
      flush_done    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          flush_done <= 1'b0;
          if (flush_req) begin
            state_r       <= ST_SWEEP;
            btb_update_en <= 1'b0;
            btb_taken     <= 1'b0;
            btb_clear_en  <= 1'b1;
            btb_clear_idx <= {IDX_W{1'b0}};
          end else begin
            btb_update_en <= pop_s;
            btb_taken     <= pop_s;
            btb_clear_en  <= 1'b0;
            if (pop_s) {btb_pc, btb_target} <= head_s;
          end
        end
        ST_SWEEP: begin
          btb_update_en <= 1'b0;
          btb_taken     <= 1'b0;
          if (btb_clear_idx == IDX_LAST) begin
            btb_clear_en <= 1'b0;
            flush_done   <= 1'b1;
            state_r      <= ST_DONE;
          end else begin
            btb_clear_idx <= btb_clear_idx + IDX_W'(1);
          end
        end
        ST_DONE: begin
          flush_done <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          state_r       <= ST_IDLE;
          btb_update_en <= 1'b0;
          btb_clear_en  <= 1'b0;
          flush_done    <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (state_r != ST_IDLE) || !empty_s || btb_update_en;

endmodule
